// File: rtl/sketch_canvas.sv
// Paint canvas for the VGA stage: 20x15 grid of RRRGGGBB cells driven by
// direction buttons with auto-repeat, a pen, and a 300-cycle clear sweep.
module sketch_canvas #(
    parameter int unsigned COLS        = 20,
    parameter int unsigned ROWS        = 15,
    parameter int unsigned MOVE_DIV    = 5000000,
    parameter logic [7:0]  CLEAR_COLOR = 8'h00
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     btn_up,
    input  logic                     btn_down,
    input  logic                     btn_left,
    input  logic                     btn_right,
    input  logic                     pen_down,
    input  logic [7:0]               color,
    input  logic                     clear,
    output logic [COLS*ROWS*8-1:0]   image,
    output logic [4:0]               cursor_x,
    output logic [3:0]               cursor_y,
    output logic                     busy
);

    localparam int unsigned CELLS = COLS * ROWS;
    localparam int unsigned CNT_W = $clog2(MOVE_DIV);

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [4:0]             cursor_x_q, cursor_x_d;
    logic [3:0]             cursor_y_q, cursor_y_d;
    logic [8:0]             idx_q, idx_d;
    logic [3:0]             btn_q;
    logic                   busy_q;
    logic [CELLS*8-1:0]     image_q;

    logic [3:0]             btn_now;
    logic [3:0]             rise;
    logic                   go_up, go_dn, go_l, go_r, active, step;
    logic [8:0]             cell_off;
    logic                   wr_en;
    logic [8:0]             wr_off;
    logic [7:0]             wr_data;

    // Direction decode: opposing buttons on one axis cancel.
    assign btn_now  = {btn_up, btn_down, btn_left, btn_right};
    assign rise     = btn_now & ~btn_q;
    assign go_up    = btn_up & ~btn_down;
    assign go_dn    = btn_down & ~btn_up;
    assign go_l     = btn_left & ~btn_right;
    assign go_r     = btn_right & ~btn_left;
    assign active   = go_up | go_dn | go_l | go_r;
    assign step     = (go_up & rise[3]) | (go_dn & rise[2]) | (go_l & rise[1]) | (go_r & rise[0])
                    | (active & (cnt_q == CNT_W'(MOVE_DIV - 1)));
    assign cell_off = 9'(cursor_y_q) * 9'(COLS) + 9'(cursor_x_q);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cursor_x_d = cursor_x_q;
        cursor_y_d = cursor_y_q;
        idx_d      = idx_q;
        wr_en      = 1'b0;
        wr_off     = cell_off;
        wr_data    = color;
        case (state_q)
            ST_IDLE: begin
                if (!active) begin
                    cnt_d = '0;
                end else if (step) begin
                    cnt_d = '0;
                    if (go_up && cursor_y_q != 4'd0)               cursor_y_d = cursor_y_q - 4'd1;
                    if (go_dn && cursor_y_q != 4'(ROWS - 1))       cursor_y_d = cursor_y_q + 4'd1;
                    if (go_l  && cursor_x_q != 5'd0)               cursor_x_d = cursor_x_q - 5'd1;
                    if (go_r  && cursor_x_q != 5'(COLS - 1))       cursor_x_d = cursor_x_q + 5'd1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                wr_en = pen_down;
                if (clear) begin
                    state_d = ST_CLEAR;
                    idx_d   = 9'd0;
                end
            end
            ST_CLEAR: begin
                cnt_d   = '0;
                wr_en   = 1'b1;
                wr_off  = idx_q;
                wr_data = CLEAR_COLOR;
                idx_d   = idx_q + 9'd1;
                if (idx_q == 9'(CELLS - 1)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            cursor_x_q <= 5'd0;
            cursor_y_q <= 4'd0;
            idx_q      <= 9'd0;
            btn_q      <= 4'd0;
            busy_q     <= 1'b0;
            image_q    <= {CELLS{CLEAR_COLOR}};
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cursor_x_q <= cursor_x_d;
            cursor_y_q <= cursor_y_d;
            idx_q      <= idx_d;
            btn_q      <= btn_now;
            busy_q     <= (state_d == ST_CLEAR);
            if (wr_en) image_q[{wr_off, 3'b000} +: 8] <= wr_data;
        end
    end

    assign image    = image_q;
    assign cursor_x = cursor_x_q;
    assign cursor_y = cursor_y_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_sketch_canvas.sv
// Bench for sketch_canvas: directed scenarios plus randomized buttons/pen/clear,
// compared every cycle against a per-cycle behavioural model of the canvas.
module tb_sketch_canvas;

    localparam int COLS  = 20;
    localparam int ROWS  = 15;
    localparam int CELLS = COLS * ROWS;
    localparam int DIV   = 4;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 bu = 1'b0, bd = 1'b0, bl = 1'b0, br = 1'b0;
    logic                 pen = 1'b0;
    logic [7:0]           color = 8'h00;
    logic                 clr = 1'b0;
    logic [CELLS*8-1:0]   image;
    logic [4:0]           cursor_x;
    logic [3:0]           cursor_y;
    logic                 busy;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state
    int         mx = 0, my = 0, rep = 0, sweep_left = 0;
    logic [3:0] prev = 4'd0;
    logic [7:0] canvas [CELLS];

    sketch_canvas #(.COLS(COLS), .ROWS(ROWS), .MOVE_DIV(DIV), .CLEAR_COLOR(8'h00)) dut (
        .clk(clk), .rst_n(rst_n),
        .btn_up(bu), .btn_down(bd), .btn_left(bl), .btn_right(br),
        .pen_down(pen), .color(color), .clear(clr),
        .image(image), .cursor_x(cursor_x), .cursor_y(cursor_y), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [CELLS*8-1:0] got, input logic [CELLS*8-1:0] exp);
        int b;
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            b = 0;
            for (int i = CELLS - 1; i >= 0; i--) if (got[i*8 +: 8] !== exp[i*8 +: 8]) b = i;
            $display("FAIL %s: byte %0d got 0x%02h expected 0x%02h (t=%0t)",
                     tag, b, got[b*8 +: 8], exp[b*8 +: 8], $time);
        end
    endtask

    function automatic int clampi(input int v, input int hi);
        return (v < 0) ? 0 : (v > hi) ? hi : v;
    endfunction

    // Advance the model by one clock edge using the current inputs.
    task automatic model_step();
        int dx, dy;
        bit fresh;
        logic [3:0] b;
        b = {bu, bd, bl, br};
        if (!rst_n) begin
            mx = 0; my = 0; rep = 0; sweep_left = 0; prev = 4'd0;
            for (int i = 0; i < CELLS; i++) canvas[i] = 8'h00;
            return;
        end
        if (sweep_left > 0) begin
            canvas[CELLS - sweep_left] = 8'h00;
            sweep_left--;
            rep = 0;
        end else begin
            dy = (bu && !bd) ? -1 : (bd && !bu) ? 1 : 0;
            dx = (bl && !br) ? -1 : (br && !bl) ? 1 : 0;
            fresh = (dy < 0 && !prev[3]) || (dy > 0 && !prev[2]) ||
                    (dx < 0 && !prev[1]) || (dx > 0 && !prev[0]);
            if (pen) canvas[my * COLS + mx] = color;
            if (dx == 0 && dy == 0) rep = 0;
            else if (fresh || rep == DIV - 1) begin
                mx = clampi(mx + dx, COLS - 1);
                my = clampi(my + dy, ROWS - 1);
                rep = 0;
            end else rep++;
            if (clr) sweep_left = CELLS;
        end
        prev = b;
    endtask

    task automatic check_all();
        logic [CELLS*8-1:0] exp_img;
        for (int i = 0; i < CELLS; i++) exp_img[i*8 +: 8] = canvas[i];
        check("cursor_x", CELLS*8'(cursor_x), CELLS*8'(mx));
        check("cursor_y", CELLS*8'(cursor_y), CELLS*8'(my));
        check("busy", CELLS*8'(busy), CELLS*8'(sweep_left > 0));
        check("image", image, exp_img);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic set_btn(input logic [3:0] b);
        {bu, bd, bl, br} = b;
    endtask

    task automatic tap(input logic [3:0] b);
        set_btn(b); tick();
        set_btn(4'd0); tick();
    endtask

    initial begin
        int n, hold, sx, sy;
        logic [CELLS*8-1:0] zero_img;
        logic [CELLS*8-1:0] one_img;
        zero_img = '0;
        for (int i = 0; i < CELLS; i++) canvas[i] = 8'h00;

        // Reset, then push into the top-left corner
        rst_n = 1'b0; tick(); tick();
        check("rst_image", image, zero_img);
        rst_n = 1'b1;
        set_btn(4'b1010);
        for (int i = 0; i < 20; i++) tick();
        check("corner_x", CELLS*8'(cursor_x), CELLS*8'(0));
        check("corner_y", CELLS*8'(cursor_y), CELLS*8'(0));
        set_btn(4'd0); tick();

        // Held right for 13 cycles steps four times, then a tap adds one
        set_btn(4'b0001);
        for (int i = 0; i < 13; i++) tick();
        check("hold13_x", CELLS*8'(cursor_x), CELLS*8'(4));
        set_btn(4'd0); tick(); tick(); tick();
        tap(4'b0001);
        check("tap_x", CELLS*8'(cursor_x), CELLS*8'(5));

        // Diagonal to the far corner, then opposing vertical buttons
        set_btn(4'b0101);
        for (int i = 0; i < 200; i++) tick();
        check("clamp_x", CELLS*8'(cursor_x), CELLS*8'(19));
        check("clamp_y", CELLS*8'(cursor_y), CELLS*8'(14));
        set_btn(4'd0); tick();
        set_btn(4'b1100);
        for (int i = 0; i < 10; i++) tick();
        check("updown_y", CELLS*8'(cursor_y), CELLS*8'(14));
        set_btn(4'd0);

        // Single paint at (3,2)
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        for (int i = 0; i < 3; i++) tap(4'b0001);
        for (int i = 0; i < 2; i++) tap(4'b0100);
        color = 8'hE0; pen = 1'b1; tick(); pen = 1'b0; tick();
        one_img = '0;
        one_img[351:344] = 8'hE0;
        check("paint_cell", CELLS*8'(image[351:344]), CELLS*8'(8'hE0));
        check("paint_only", image, one_img);

        // Paint a few more cells, then clear with noise on the inputs
        color = 8'h1C; pen = 1'b1;
        tap(4'b0001); tap(4'b0100);
        color = 8'h03; tap(4'b0010);
        pen = 1'b0; tick();
        sx = mx; sy = my;
        clr = 1'b1; tick(); clr = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 400) begin
            set_btn(4'($urandom)); pen = 1'($urandom); color = 8'($urandom); clr = 1'($urandom);
            n++;
            tick();
        end
        set_btn(4'd0); pen = 1'b0; clr = 1'b0;
        check("busy_len", CELLS*8'(n), CELLS*8'(300));
        check("clear_image", image, zero_img);
        check("clear_cur_x", CELLS*8'(cursor_x), CELLS*8'(sx));
        check("clear_cur_y", CELLS*8'(cursor_y), CELLS*8'(sy));
        tick();

        // Randomized traffic
        hold = 0;
        for (int c = 0; c < 1500; c++) begin
            if (hold == 0) begin
                set_btn(($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom));
                hold = $urandom_range(1, 10);
            end
            hold--;
            pen   = ($urandom_range(0, 2) == 0);
            color = 8'($urandom);
            clr   = ($urandom_range(0, 299) == 0);
            tick();
        end
        set_btn(4'd0); pen = 1'b0; clr = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 400) begin n++; tick(); end
        tick();

        // Reset in the middle of a sweep
        color = 8'h55; pen = 1'b1; tap(4'b0001); pen = 1'b0;
        clr = 1'b1; tick(); clr = 1'b0;
        for (int i = 0; i < 150; i++) tick();
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        check("rst_mid_busy", CELLS*8'(busy), CELLS*8'(0));
        check("rst_mid_x", CELLS*8'(cursor_x), CELLS*8'(0));
        check("rst_mid_y", CELLS*8'(cursor_y), CELLS*8'(0));
        check("rst_mid_image", image, zero_img);
        tap(4'b0001);
        check("post_rst_x", CELLS*8'(cursor_x), CELLS*8'(1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
